fetch: RTL and testbench

Instruction-fetch stage with the IF/ID pipeline register, directly upstream of the decode stage.
- Owns the program counter and drives the instruction-memory address.
- Registers the fetched instruction and delivers PC, PC+1 and instruction to decode.
- Handles branch/jump redirects from execute, halt and stall holds, and single-level interrupt entry/return using the decode-stage int_done pulse.

---
 rtl/fetch.sv | 111 +++++++++++
 tb/tb_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and holds the IF/ID register.
// Handles redirect flushes, halt/stall holds and single-level interrupt entry/return.
module fetch #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] ISR_VECTOR = 16'h0100,
    parameter logic [15:0] NOP_INST   = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    input  logic        halt,
    input  logic        int_done,
    input  logic        int_req,
    output logic        int_ack,
    output logic        in_isr,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus1_out,
    output logic [15:0] inst_out
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] pc_plus1_q, pc_plus1_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] saved_pc_q, saved_pc_d;
    logic        int_ack_q, int_ack_d;
    logic        in_isr_q, in_isr_d;
    logic        flush;

    // Next-state selection in event priority order
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_out_d   = pc_out_q;
        pc_plus1_d = pc_plus1_q;
        inst_d     = inst_q;
        saved_pc_d = saved_pc_q;
        int_ack_d  = 1'b0;
        flush      = 1'b0;

        if (redirect) begin
            pc_d  = redirect_pc;
            flush = 1'b1;
        end else if (int_done && state_q == ST_ISR) begin
            pc_d    = saved_pc_q;
            flush   = 1'b1;
            state_d = ST_RUN;
        end else if (halt || stall) begin
            pc_d = pc_q;
        end else if (int_req && state_q == ST_RUN) begin
            saved_pc_d = pc_q;
            pc_d       = ISR_VECTOR;
            flush      = 1'b1;
            state_d    = ST_ISR;
            int_ack_d  = 1'b1;
        end else begin
            pc_out_d   = pc_q;
            pc_plus1_d = pc_q + 16'd1;
            inst_d     = imem_data;
            pc_d       = pc_q + 16'd1;
        end

        if (flush) begin
            pc_out_d   = 16'h0000;
            pc_plus1_d = 16'h0000;
            inst_d     = NOP_INST;
        end

        in_isr_d = (state_d == ST_ISR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pc_out_q   <= 16'h0000;
            pc_plus1_q <= 16'h0000;
            inst_q     <= NOP_INST;
            saved_pc_q <= 16'h0000;
            int_ack_q  <= 1'b0;
            in_isr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_out_q   <= pc_out_d;
            pc_plus1_q <= pc_plus1_d;
            inst_q     <= inst_d;
            saved_pc_q <= saved_pc_d;
            int_ack_q  <= int_ack_d;
            in_isr_q   <= in_isr_d;
        end
    end

    assign imem_addr    = pc_q;
    assign pc_out       = pc_out_q;
    assign pc_plus1_out = pc_plus1_q;
    assign inst_out     = inst_q;
    assign int_ack      = int_ack_q;
    assign in_isr       = in_isr_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios then randomized events, all checked against a cycle model.
module tb_fetch;

    localparam logic [15:0] RST_PC  = 16'h0000;
    localparam logic [15:0] ISR_VEC = 16'h0100;
    localparam logic [15:0] NOP     = 16'h1000;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        halt;
    logic        int_done;
    logic        int_req;
    logic        int_ack;
    logic        in_isr;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1_out;
    logic [15:0] inst_out;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference state
    logic [15:0] m_pc, m_pc_out, m_pc1, m_inst, m_saved;
    bit          m_isr, m_ack;

    fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .halt        (halt),
        .int_done    (int_done),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .in_isr      (in_isr),
        .pc_out      (pc_out),
        .pc_plus1_out(pc_plus1_out),
        .inst_out    (inst_out)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    assign imem_data = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("imem_addr", imem_addr, m_pc);
        check("pc_out", pc_out, m_pc_out);
        check("pc_plus1_out", pc_plus1_out, m_pc1);
        check("inst_out", inst_out, m_inst);
        check("int_ack", 16'(int_ack), 16'(m_ack));
        check("in_isr", 16'(in_isr), 16'(m_isr));
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_pc_out = 16'h0; m_pc1 = 16'h0; m_inst = NOP;
        m_saved = 16'h0; m_isr = 0; m_ack = 0;
    endtask

    // One clock of the reference: decide which rule applies, then apply it
    task automatic model_step(input bit r, input logic [15:0] rpc, input bit st,
                              input bit h, input bit id, input bit ir);
        bit          fl;
        logic [15:0] npc;
        fl    = 0;
        npc   = m_pc;
        m_ack = 0;
        if (r) begin
            npc = rpc; fl = 1;
        end else if (id && m_isr) begin
            npc = m_saved; fl = 1; m_isr = 0;
        end else if (h || st) begin
            npc = m_pc;
        end else if (ir && !m_isr) begin
            m_saved = m_pc; npc = ISR_VEC; fl = 1; m_isr = 1; m_ack = 1;
        end else begin
            m_pc_out = m_pc;
            m_pc1    = m_pc + 16'd1;
            m_inst   = mem_word(m_pc);
            npc      = m_pc + 16'd1;
        end
        if (fl) begin
            m_pc_out = 16'h0; m_pc1 = 16'h0; m_inst = NOP;
        end
        m_pc = npc;
    endtask

    // Called at a falling edge: drive, clock, model, check at next falling edge
    task automatic cycle(input bit r, input logic [15:0] rpc, input bit st,
                         input bit h, input bit id, input bit ir);
        redirect = r; redirect_pc = rpc; stall = st; halt = h; int_done = id; int_req = ir;
        @(posedge clk);
        model_step(r, rpc, st, h, id, ir);
        @(negedge clk);
        check_all();
    endtask

    task automatic seq(input int n, input bit ir);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 0, 0, 0, ir);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_inst_out", inst_out, NOP);
        check("rst_pc_out", pc_out, 16'h0);
        check("rst_pc_plus1", pc_plus1_out, 16'h0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_in_isr", 16'(in_isr), 16'h0);
        check("rst_int_ack", 16'(int_ack), 16'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; redirect = 0; redirect_pc = 16'h0; stall = 0; halt = 0;
        int_done = 0; int_req = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all();

        // Plain sequential fetch from reset
        seq(4, 0);
        async_reset();
        check_all();

        // Wrap at 16'hFFFF
        cycle(1, 16'hFFFF, 0, 0, 0, 0);
        seq(3, 0);

        // Stall at pc=5, then redirect overriding stall
        cycle(1, 16'h0005, 0, 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 0, 1);
        cycle(0, 16'h0, 1, 0, 0, 0);
        cycle(1, 16'h0040, 1, 0, 0, 0);
        seq(2, 0);

        // Interrupt entry, ignored re-request, return
        cycle(1, 16'h0010, 0, 0, 0, 0);
        cycle(0, 16'h0, 0, 0, 0, 1);
        seq(3, 1);
        cycle(0, 16'h0, 0, 0, 1, 0);
        seq(2, 0);

        // Halt with pending interrupt, released by redirect
        cycle(0, 16'h0, 0, 1, 0, 1);
        cycle(0, 16'h0, 0, 1, 0, 1);
        cycle(0, 16'h0, 0, 1, 0, 1);
        cycle(1, 16'h0020, 0, 1, 0, 0);
        seq(2, 0);

        // Redirect wins over int_done inside ISR
        cycle(0, 16'h0, 0, 0, 0, 1);
        seq(1, 0);
        cycle(1, 16'h0200, 0, 0, 1, 0);
        seq(2, 0);
        cycle(0, 16'h0, 0, 0, 1, 0);
        seq(2, 0);

        // int_done outside ISR is a plain fetch
        cycle(0, 16'h0, 0, 0, 1, 0);

        // Randomized event mix
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
                check_all();
            end else begin
                cycle($urandom_range(0, 15) == 0, 16'($urandom),
                      $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
